// File: rtl/cam_match_sequencer_pkg.sv
// Shared definitions for the CAM match sequencer: vector and index widths,
// FSM state encoding and a few width-exact constants.
`ifndef SASA_CAM_len
`define SASA_CAM_len 256
`endif

package cam_match_sequencer_pkg;

    localparam int CAM_LEN = `SASA_CAM_len;
    localparam int IDX_W = $clog2(CAM_LEN);
    localparam int CNT_W = IDX_W + 1;

    localparam logic [CAM_LEN-1:0] VEC_ONE  = {{(CAM_LEN-1){1'b0}}, 1'b1};
    localparam logic [CAM_LEN-1:0] VEC_ONES = {CAM_LEN{1'b1}};
    localparam logic [CNT_W-1:0]   CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } seqState_t;

endpackage

// File: rtl/cam_match_sequencer_if.sv
// Handshake bundle between the CAM search result, the sequencer and the
// downstream entry-read/update logic. The sequencer uses the slave view.
interface cam_match_sequencer_if;
    import cam_match_sequencer_pkg::*;

    logic               in_valid;
    logic               in_ready;
    logic [CAM_LEN-1:0] in_vector;
    logic               abort;
    logic               out_valid;
    logic               out_ready;
    logic [CAM_LEN-1:0] out_onehot;
    logic [IDX_W-1:0]   out_index;
    logic               out_last;
    logic               done;
    logic [CNT_W-1:0]   hit_cnt;
    logic               busy;

    modport master (
        output in_valid, in_vector, abort, out_ready,
        input  in_ready, out_valid, out_onehot, out_index, out_last, done, hit_cnt, busy
    );

    modport slave (
        input  in_valid, in_vector, abort, out_ready,
        output in_ready, out_valid, out_onehot, out_index, out_last, done, hit_cnt, busy
    );

endinterface

// File: rtl/cam_match_sequencer_msb_onehot_sel.sv
// Highest-set-bit selector: halves the search window IDX_W times, taking the
// upper half whenever it holds any bit, so the index falls out MSB first.
module msb_onehot_sel
    import cam_match_sequencer_pkg::*;
(
    input  logic [CAM_LEN-1:0] vec,
    output logic [CAM_LEN-1:0] onehot,
    output logic [IDX_W-1:0]   index
);

    logic [CAM_LEN-1:0] window_s;
    logic [CAM_LEN-1:0] upperHalf_s;
    logic [CAM_LEN-1:0] lowerHalf_s;
    logic [CAM_LEN-1:0] halfMask_s;
    logic [IDX_W-1:0]   index_s;
    logic               anySet_s;

    // Halving tree: each stage resolves one index bit, from MSB down to LSB.
    always_comb begin
        window_s    = vec;
        index_s     = '0;
        upperHalf_s = '0;
        lowerHalf_s = '0;
        halfMask_s  = '0;
        for (int s = IDX_W - 1; s >= 0; s--) begin
            halfMask_s  = VEC_ONES >> (CAM_LEN - (1 << s));
            upperHalf_s = (window_s >> (1 << s)) & halfMask_s;
            lowerHalf_s = window_s & halfMask_s;
            if (upperHalf_s != '0) begin
                index_s[s] = 1'b1;
                window_s   = upperHalf_s;
            end else begin
                window_s   = lowerHalf_s;
            end
        end
    end

    assign anySet_s = |vec;
    assign index    = index_s;
    // An empty vector must not produce a phantom bit 0.
    assign onehot   = anySet_s ? (VEC_ONE << index_s) : '0;

endmodule

// File: rtl/cam_match_sequencer.sv
// CAM match sequencer: captures a match vector, issues every set line
// highest-first one per handshake, then pulses done with the hit count.
module cam_match_sequencer
    import cam_match_sequencer_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    cam_match_sequencer_if.slave  bus
);

    seqState_t          state_r;
    seqState_t          stateNext_s;
    logic [CAM_LEN-1:0] pending_r;
    logic [CNT_W-1:0]   count_r;
    logic [CNT_W-1:0]   hitCnt_r;

    logic [CAM_LEN-1:0] selOnehot_s;
    logic [IDX_W-1:0]   selIndex_s;
    logic               lastMatch_s;
    logic               accept_s;
    logic               handshake_s;

    logic               inReady_s;
    logic               outValid_s;
    logic [CAM_LEN-1:0] outOnehot_s;
    logic [IDX_W-1:0]   outIndex_s;
    logic               outLast_s;
    logic               done_s;
    logic               busy_s;

    msb_onehot_sel u_sel (
        .vec    (pending_r),
        .onehot (selOnehot_s),
        .index  (selIndex_s)
    );

    assign lastMatch_s = ((pending_r & ~selOnehot_s) == '0);
    assign accept_s    = bus.in_valid && inReady_s;
    assign handshake_s = outValid_s && bus.out_ready;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= stateNext_s;
        end
    end

    // Next-state logic; abort overrides every other transition.
    always_comb begin
        stateNext_s = state_r;
        if (bus.abort) begin
            stateNext_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        stateNext_s = (bus.in_vector != '0) ? ISSUE : DONE;
                    end else begin
                        stateNext_s = IDLE;
                    end
                end
                ISSUE: begin
                    if (handshake_s && lastMatch_s) begin
                        stateNext_s = DONE;
                    end else begin
                        stateNext_s = ISSUE;
                    end
                end
                DONE:    stateNext_s = IDLE;
                default: stateNext_s = IDLE;
            endcase
        end
    end

    // Output decode; match fields are forced to zero outside ISSUE.
    always_comb begin
        inReady_s   = 1'b0;
        outValid_s  = 1'b0;
        outOnehot_s = '0;
        outIndex_s  = '0;
        outLast_s   = 1'b0;
        done_s      = 1'b0;
        case (state_r)
            IDLE: inReady_s = !bus.abort;
            ISSUE: begin
                outValid_s  = 1'b1;
                outOnehot_s = selOnehot_s;
                outIndex_s  = selIndex_s;
                outLast_s   = lastMatch_s;
            end
            DONE:    done_s = 1'b1;
            default: inReady_s = 1'b0;
        endcase
        busy_s = (state_r != IDLE);
    end

    // Pending vector and issued-match counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_r <= '0;
            count_r   <= '0;
        end else if (bus.abort) begin
            pending_r <= '0;
            count_r   <= '0;
        end else if (accept_s) begin
            pending_r <= bus.in_vector;
            count_r   <= '0;
        end else if (handshake_s) begin
            pending_r <= pending_r & ~selOnehot_s;
            count_r   <= count_r + CNT_ONE;
        end else begin
            pending_r <= pending_r;
            count_r   <= count_r;
        end
    end

    // Hit count captured on entry to DONE so it is valid alongside the done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            hitCnt_r <= '0;
        end else if (stateNext_s == DONE) begin
            hitCnt_r <= (state_r == ISSUE) ? (count_r + CNT_ONE) : '0;
        end else begin
            hitCnt_r <= hitCnt_r;
        end
    end

    assign bus.in_ready   = inReady_s;
    assign bus.out_valid  = outValid_s;
    assign bus.out_onehot = outOnehot_s;
    assign bus.out_index  = outIndex_s;
    assign bus.out_last   = outLast_s;
    assign bus.done       = done_s;
    assign bus.hit_cnt    = hitCnt_r;
    assign bus.busy       = busy_s;

endmodule
